// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers {pc, inst} pairs from the I-cache for decode
// and gates PC advance so each fetched address is captured exactly once.

module inst_fetch_queue_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             we,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [WIDTH-1:0] inst_d,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] inst_q
);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else if (we) begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end
endmodule

module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [WIDTH-1:0]         addrIn,
    input  logic [WIDTH-1:0]         instIn,
    input  logic                     instValid,
    input  logic                     jumpIn,
    output logic                     lockerOut,
    output logic [WIDTH-1:0]         pcOut,
    output logic [WIDTH-1:0]         instOut,
    output logic                     validOut,
    input  logic                     readyIn,
    output logic [$clog2(DEPTH):0]   countOut
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q;
    logic   [AW-1:0]    rd_ptr, wr_ptr;
    logic   [CW-1:0]    count;
    logic               full, empty, push, pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Push never looks at readyIn: a full queue refuses even when draining,
    // which keeps lockerOut free of any path from decode.
    assign push      = instValid && !full && !jumpIn;
    assign pop       = validOut && readyIn && !jumpIn;
    assign lockerOut = jumpIn || push;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            inst_fetch_queue_entry #(.WIDTH(WIDTH)) u_ent (
                .clk    (clk),
                .resetN (resetN),
                .we     (push && (wr_ptr == AW'(i))),
                .pc_d   (addrIn),
                .inst_d (instIn),
                .pc_q   (ent_q[i].pc),
                .inst_q (ent_q[i].inst)
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jumpIn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign validOut = !empty;
    assign pcOut    = ent_q[rd_ptr].pc;
    assign instOut  = ent_q[rd_ptr].inst;
    assign countOut = count;
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the instruction cache and the decode stage. It captures each {PC, instruction} pair returned for the address currently driven by `PC` and buffers up to DEPTH of them. It presents the oldest pair to decode through a valid/ready handshake. It drives `PC`'s `locker` input so the PC advances only when the current fetch is accepted, and it flushes on a taken jump.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- WIDTH, 32, width of PC and instruction words (matches `DataSize`)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- resetN  input  1  reset; one clock, asynchronous assert, active-low; clears all state immediately
- addrIn  input  WIDTH  PC of the instruction on `instIn` (from `PC.addrOut`)
- instIn  input  WIDTH  instruction word from the instruction cache
- instValid  input  1  `instIn` is valid for `addrIn` this cycle
- jumpIn  input  1  taken jump/branch; same signal as `PC.select`
- lockerOut  output  1  to `PC.locker`; 1 = PC may advance, 0 = PC holds
- pcOut  output  WIDTH  PC of the head entry
- instOut  output  WIDTH  instruction of the head entry
- validOut  output  1  head entry valid
- readyIn  input  1  decode accepts the head entry (0 = stall from hazard unit)
- countOut  output  log2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer holding {pc, inst}, with a read pointer, a write pointer and a count register.
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count ranges 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- push = instValid && !full && !jumpIn. Writes {addrIn, instIn} at the write pointer, then increments it.
- pop = validOut && readyIn && !jumpIn. Increments the read pointer.
- count update:
  - push and pop together: count unchanged.
  - push only: count + 1.
  - pop only: count - 1.
- lockerOut = jumpIn || push (combinational).
  - The PC holds whenever the current fetch is not captured: cache miss, or queue full.
  - This ensures no instruction is skipped or duplicated.
- A push into a full queue is never accepted, even when a pop occurs in the same cycle.
  - In that case the PC holds and the cache re-presents the same address next cycle.
- validOut = !empty. pcOut and instOut are a combinational read of the head entry.
  - When empty, pcOut and instOut show the stale head contents; they are don't-care while validOut = 0.
- Flush (jumpIn = 1): on the edge, read pointer, write pointer and count all go to 0.
  - The same-cycle push is discarded.
  - Any handshake with decode in that cycle is void. Decode squashes its own input on jumpIn.
- Reset (resetN = 0, at any time, including mid-transfer): pointers, count and all entries clear to 0 immediately, without waiting for a clock edge.

## Timing
- Reset values: validOut 0, pcOut 0, instOut 0, countOut 0.
  - lockerOut follows its equation: 0 while instValid = 0.
- Latency: a pair pushed at edge N is visible on validOut/pcOut/instOut after edge N when the queue was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained. Occupancy stays constant while both occur.
- Flush: validOut = 0 in the cycle after the jumpIn edge. The first post-jump instruction can be pushed in that same cycle (the PC already holds addrJump) and appears one cycle later.
- Reset release: the first push can occur at the first rising edge after resetN goes high.
- No combinational path from readyIn to lockerOut.
- lockerOut depends combinationally on instValid, jumpIn and registered count only.

## Test plan
- Reset then stream: release reset and present PCs 0x0, 0x4, 0x8, ... with instValid = 1 and readyIn = 1. Required: validOut first rises one cycle after the first push; pcOut follows in order; countOut stays at 1; lockerOut stays at 1.
- Fill and stall: readyIn = 0 and instValid = 1 with PCs 0x0 to 0xC. Required: countOut reaches 4; lockerOut = 0 with addrIn held at 0x10. Then readyIn = 1 for one cycle. Required: pop of 0x0, no push that cycle; 0x10 is pushed the next cycle; the drained order is 0x0, 0x4, 0x8, 0xC, 0x10 with no duplicates.
- Cache miss: instValid = 0 for 3 cycles mid-stream. Required: lockerOut = 0 and no push during the miss; the queue drains normally; instructions resume in order with no gap in the PC sequence.
- Flush: with count = 3, assert jumpIn for one cycle, with a concurrent push and pop. Required: next cycle countOut = 0 and validOut = 0. The next pushed instruction, addrIn = jump target 0x100, appears at pcOut as the head.
- Wrap-around: run 10 push/pop cycles with varying readyIn. Required: the pointers wrap past entry 3 and the output order matches the input order exactly.
- Async reset mid-operation: assert resetN low between edges with count = 2. Required: validOut and countOut go to 0 before the next clock edge; the contents are cleared to 0.
